// File: rtl/dvs_ravens_pkg.sv
// Shared types and defaults for the DVS front end feeding the RAVENS core.
package dvs_ravens_pkg;

  localparam int unsigned DVS_X_ADDR_BITS   = 8;
  localparam int unsigned DVS_Y_ADDR_BITS   = 8;
  localparam int unsigned TIMESTAMP_US_BITS = 16;

  localparam int unsigned SCHED_NUM_CH     = 4;
  localparam int unsigned SCHED_FIFO_DEPTH = 4;
  localparam int unsigned SCHED_DROP_BITS  = 16;

  typedef struct packed {
    logic [DVS_X_ADDR_BITS-1:0]   x;
    logic [DVS_Y_ADDR_BITS-1:0]   y;
    logic [TIMESTAMP_US_BITS-1:0] timestamp;
    logic                         polarity;
  } dvs_event_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/dvs_rr_arbiter.sv
// Round-robin arbiter; the pointer names the channel with highest priority
// and moves to one past the winner only when a grant is taken.
module dvs_rr_arbiter #(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              grant_en,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any_req
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned      pos;
    logic [IDX_W-1:0] cand;
    pos       = 0;
    cand      = '0;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    // Explicit wrap keeps the search correct for non-power-of-2 channel counts.
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      pos = 32'(ptr_q) + off;
      if (pos >= NUM_CH) begin
        pos = pos - NUM_CH;
      end
      cand = IDX_W'(pos);
      if (!any_req && req[cand]) begin
        any_req   = 1'b1;
        grant_idx = cand;
      end
    end
    grant[grant_idx] = any_req;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en && any_req) begin
      ptr_d = (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dvs_event_scheduler.sv
// Merges per-channel DVS event strobes through small FIFOs and a round-robin
// arbiter onto a single registered valid/ready event bus, counting overflow drops.
module dvs_event_scheduler
  import dvs_ravens_pkg::*;
#(
  parameter  int unsigned NUM_CH     = SCHED_NUM_CH,
  parameter  int unsigned FIFO_DEPTH = SCHED_FIFO_DEPTH,
  parameter  int unsigned DROP_BITS  = SCHED_DROP_BITS,
  localparam int unsigned CH_W       = $clog2(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic       [NUM_CH-1:0]       in_valid,
  input  dvs_event_t [NUM_CH-1:0]       in_event,
  output logic                          out_valid,
  input  logic                          out_ready,
  output dvs_event_t                    out_event,
  output logic       [CH_W-1:0]         out_ch,
  output logic       [NUM_CH-1:0]       drop_pulse,
  output logic       [DROP_BITS-1:0]    drop_count,
  input  logic                          drop_count_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [DROP_BITS-1:0] DROP_MAX = '1;

  logic              load_en;
  logic [NUM_CH-1:0] not_empty;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              any_req;
  logic [NUM_CH-1:0] drop_now;
  dvs_event_t        head [NUM_CH];

  logic                 out_valid_q, out_valid_d;
  dvs_event_t           out_event_q, out_event_d;
  logic [CH_W-1:0]      out_ch_q, out_ch_d;
  logic [NUM_CH-1:0]    drop_pulse_q, drop_pulse_d;
  logic [DROP_BITS-1:0] drop_count_q, drop_count_d;

  assign load_en = !out_valid_q || out_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    dvs_event_t  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        empty, full, push, pop;

    always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop   = load_en && grant[g];
      // A same-edge pop frees the head slot, so a push into a full FIFO still fits.
      push  = in_valid[g] && (!full || pop);
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    assign drop_now[g]  = in_valid[g] && full && !(load_en && grant[g]);
    assign not_empty[g] = !empty;
    assign head[g]      = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= in_event[g];
      end
    end
  end

  dvs_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (not_empty),
    .grant_en  (load_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_event_d = out_event_q;
    out_ch_d    = out_ch_q;
    if (load_en) begin
      out_valid_d = any_req;
      if (any_req) begin
        out_event_d = head[grant_idx];
        out_ch_d    = grant_idx;
      end
    end
  end

  always_comb begin
    logic [DROP_BITS-1:0] base;
    logic [DROP_BITS-1:0] inc;
    drop_pulse_d = drop_now;
    inc          = DROP_BITS'(popcount8(8'(drop_now)));
    base         = drop_count_clr ? '0 : drop_count_q;
    drop_count_d = (base > DROP_MAX - inc) ? DROP_MAX : base + inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_event_q  <= '0;
      out_ch_q     <= '0;
      drop_pulse_q <= '0;
      drop_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_event_q  <= out_event_d;
      out_ch_q     <= out_ch_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_event  = out_event_q;
  assign out_ch     = out_ch_q;
  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;

endmodule
